alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 119 +++++++++++
 tb/tb_alu_op_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: single-outstanding command sequencer around an external ALU,
// waiting SETTLE_CYCLES after operand drive before capturing the result.
// Define ALU_SEQ_STATUS_ACCUM_EN to add sticky overflow status and a saturating overflow count.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ALU_SEQ_STATUS_ACCUM_EN
  input  logic        status_clr,
  output logic        ovf_sticky,
  output logic [7:0]  ovf_count,
`endif
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_s,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_s,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       accept, capture;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // cmd_ready is low in RESP even during the response handshake, so a new
  // command can only be taken the cycle after the sequencer returns to IDLE.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      rsp_s        <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
        cnt    <= SETTLE_LD;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_s        <= alu_s;
        rsp_overflow <= alu_overflow;
        rsp_zero     <= alu_zero;
      end
    end
  end

`ifdef ALU_SEQ_STATUS_ACCUM_EN
  logic ovf_hit;
  assign ovf_hit = rsp_valid && rsp_ready && rsp_overflow;

  always_ff @(posedge clk) begin
    if (rst || status_clr) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (ovf_hit) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != '1) ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: two instances (SETTLE_CYCLES 1 and 3)
// share stimulus; a behavioural ALU drives each instance's result inputs.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, rsp_ready;
  logic [15:0] cmd_a, cmd_b;
  logic [3:0]  cmd_op;

  logic        d1_cmd_ready, d1_rsp_valid, d1_rsp_overflow, d1_rsp_zero, d1_busy;
  logic        d1_alu_overflow, d1_alu_zero;
  logic [15:0] d1_alu_a, d1_alu_b, d1_alu_s, d1_rsp_s;
  logic [3:0]  d1_alu_op;

  logic        d3_cmd_ready, d3_rsp_valid, d3_rsp_overflow, d3_rsp_zero, d3_busy;
  logic        d3_alu_overflow, d3_alu_zero;
  logic [15:0] d3_alu_a, d3_alu_b, d3_alu_s, d3_rsp_s;
  logic [3:0]  d3_alu_op;

`ifdef ALU_SEQ_STATUS_ACCUM_EN
  logic       status_clr;
  logic       d1_ovf_sticky, d3_ovf_sticky;
  logic [7:0] d1_ovf_count, d3_ovf_count;
`endif

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef ALU_SEQ_STATUS_ACCUM_EN
    .status_clr(status_clr), .ovf_sticky(d1_ovf_sticky), .ovf_count(d1_ovf_count),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(d1_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op),
    .alu_s(d1_alu_s), .alu_overflow(d1_alu_overflow), .alu_zero(d1_alu_zero),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_s(d1_rsp_s),
    .rsp_overflow(d1_rsp_overflow), .rsp_zero(d1_rsp_zero), .busy(d1_busy)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
`ifdef ALU_SEQ_STATUS_ACCUM_EN
    .status_clr(status_clr), .ovf_sticky(d3_ovf_sticky), .ovf_count(d3_ovf_count),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(d3_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op),
    .alu_s(d3_alu_s), .alu_overflow(d3_alu_overflow), .alu_zero(d3_alu_zero),
    .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_s(d3_rsp_s),
    .rsp_overflow(d3_rsp_overflow), .rsp_zero(d3_rsp_zero), .busy(d3_busy)
  );

  // Behavioural ALU: 1 add, 2 sub, 3 and, 4 xor, otherwise pass a.
  function automatic logic [17:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
    logic [15:0] s;
    logic        ovf;
    ovf = 1'b0;
    case (op)
      4'h1: begin s = a + b; ovf = (a[15] == b[15]) && (s[15] != a[15]); end
      4'h2: begin s = a - b; ovf = (a[15] != b[15]) && (s[15] != a[15]); end
      4'h3: s = a & b;
      4'h4: s = a ^ b;
      default: s = a;
    endcase
    return {ovf, (s == 16'h0000), s};
  endfunction

  always_comb {d1_alu_overflow, d1_alu_zero, d1_alu_s} = alu_model(d1_alu_a, d1_alu_b, d1_alu_op);
  always_comb {d3_alu_overflow, d3_alu_zero, d3_alu_s} = alu_model(d3_alu_a, d3_alu_b, d3_alu_op);

  logic        sel3;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_overflow, o_rsp_zero, o_busy;
  logic [15:0] o_alu_a, o_alu_b, o_rsp_s;
  logic [3:0]  o_alu_op;

  always_comb begin
    o_cmd_ready    = sel3 ? d3_cmd_ready    : d1_cmd_ready;
    o_rsp_valid    = sel3 ? d3_rsp_valid    : d1_rsp_valid;
    o_rsp_overflow = sel3 ? d3_rsp_overflow : d1_rsp_overflow;
    o_rsp_zero     = sel3 ? d3_rsp_zero     : d1_rsp_zero;
    o_busy         = sel3 ? d3_busy         : d1_busy;
    o_alu_a        = sel3 ? d3_alu_a        : d1_alu_a;
    o_alu_b        = sel3 ? d3_alu_b        : d1_alu_b;
    o_alu_op       = sel3 ? d3_alu_op       : d1_alu_op;
    o_rsp_s        = sel3 ? d3_rsp_s        : d1_rsp_s;
  end

  typedef struct packed {
    logic [15:0] s;
    logic        ovf;
    logic        zero;
  } rsp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] s;
    logic        ovf;
    logic        zero;
  } vec_t;

  rsp_t q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] s, input logic ovf, input logic zero);
    rsp_t e;
    e.s = s; e.ovf = ovf; e.zero = zero;
    q.push_back(e);
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: response %0h with empty scoreboard", tag, o_rsp_s);
    end else begin
      e = q.pop_front();
      check({tag, "_s"},    32'(o_rsp_s),        32'(e.s));
      check({tag, "_ovf"},  32'(o_rsp_overflow), 32'(e.ovf));
      check({tag, "_zero"}, 32'(o_rsp_zero),     32'(e.zero));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, 32'(o_cmd_ready),    1);
    check({tag, "_busy"},      32'(o_busy),         0);
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid),    0);
    check({tag, "_rsp_s"},     32'(o_rsp_s),        0);
    check({tag, "_rsp_flags"}, 32'({o_rsp_overflow, o_rsp_zero}), 0);
    check({tag, "_alu_a"},     32'(o_alu_a),        0);
    check({tag, "_alu_b"},     32'(o_alu_b),        0);
    check({tag, "_alu_op"},    32'(o_alu_op),       0);
  endtask

  // Command presented during reset must not be accepted.
  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1;
    cmd_a = 16'hDEAD; cmd_b = 16'hBEEF; cmd_op = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    q.delete();
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input int settle);
    int lat;
    check("op_idle_ready", 32'(o_cmd_ready), 1);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = 16'(~a); cmd_b = 16'(~b); cmd_op = 4'(~op);
    check("op_alu_a", 32'(o_alu_a), 32'(a));
    check("op_alu_b", 32'(o_alu_b), 32'(b));
    check("op_alu_op", 32'(o_alu_op), 32'(op));
    check("op_busy", 32'(o_busy), 1);
    check("op_wait_ready", 32'(o_cmd_ready), 0);
    lat = 0;
    while (!o_rsp_valid && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    check("op_latency", lat, settle);
    check_rsp("op");
    check("op_hold_a", 32'(o_alu_a), 32'(a));
    rsp_ready = 1'b1;
    check("op_no_bypass", 32'(o_cmd_ready), 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("op_rsp_done", 32'(o_rsp_valid), 0);
    check("op_ready_after", 32'(o_cmd_ready), 1);
  endtask

  task automatic throughput(input int s);
    int last, n_acc, guard;
    do_reset();
    last = -1; n_acc = 0;
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 4'h1; cmd_b = 16'h0002;
    for (int cyc = 0; cyc < 4 * (s + 2); cyc++) begin
      cmd_a = 16'(cyc);
      if (o_rsp_valid) check_rsp("tput");
      if (o_cmd_ready) begin
        if (last >= 0) check("tput_interval", cyc - last, s + 2);
        last = cyc;
        n_acc++;
        push_exp(16'(cyc + 2), 1'b0, 1'b0);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("tput_accepts", n_acc, 4);
    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      if (o_rsp_valid) check_rsp("tput_drain");
      @(posedge clk); #1;
      guard++;
    end
    check("tput_drained", q.size(), 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{16'h0003, 16'h0004, 4'h1, 16'h0007, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 4'h1, 16'h8000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0005, 4'h2, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 4'h2, 16'h7FFF, 1'b1, 1'b0};
    vecs[4] = '{16'hF0F0, 16'h0FF0, 4'h3, 16'h00F0, 1'b0, 1'b0};
    vecs[5] = '{16'hAAAA, 16'hAAAA, 4'h4, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{16'hFFFF, 16'h0001, 4'h1, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h1357, 16'h9999, 4'hF, 16'h1357, 1'b0, 1'b0};

    sel3 = 1'b0;
`ifdef ALU_SEQ_STATUS_ACCUM_EN
    status_clr = 1'b0;
`endif
    do_reset();
    check_reset_state("rst_d1");
    sel3 = 1'b1; #1;
    check_reset_state("rst_d3");

    sel3 = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].s, vecs[i].ovf, vecs[i].zero);
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 1);
    end

    sel3 = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].s, vecs[i].ovf, vecs[i].zero);
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 3);
    end

    // Stalled response on the 3-cycle instance with new commands offered.
    do_reset();
    push_exp(16'h2345, 1'b0, 1'b0);
    cmd_a = 16'h1234; cmd_b = 16'h1111; cmd_op = 4'h1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("hold_alu_a", 32'(o_alu_a), 32'h1234);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("hold_valid_edge", 32'(o_rsp_valid), 32'(i == 3));
    end
    check_rsp("hold");
    cmd_valid = 1'b1; cmd_a = 16'hFFFF; cmd_b = 16'hFFFF; cmd_op = 4'h2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(o_rsp_valid), 1);
      check("hold_rsp_s", 32'(o_rsp_s), 32'h2345);
      check("hold_ready", 32'(o_cmd_ready), 0);
      check("hold_alu_a_stable", 32'(o_alu_a), 32'h1234);
      check("hold_alu_op_stable", 32'(o_alu_op), 32'h1);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    check("hold_no_bypass", 32'(o_cmd_ready), 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("hold_done_valid", 32'(o_rsp_valid), 0);
    check("hold_done_ready", 32'(o_cmd_ready), 1);
    check("hold_done_busy", 32'(o_busy), 0);
    check("hold_done_alu_a", 32'(o_alu_a), 32'h1234);

    sel3 = 1'b0;
    throughput(1);
    sel3 = 1'b1;
    throughput(3);

    // Reset while waiting on the ALU, with a handshake attempt on the same edge.
    do_reset();
    cmd_a = 16'h00AA; cmd_b = 16'h0055; cmd_op = 4'h1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_busy", 32'(o_busy), 1);
    rst = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0;
    check_reset_state("rstw");
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (o_rsp_valid) n++;
    end
    check("rstw_no_rsp", n, 0);

    // Reset while the response is being handshaked.
    sel3 = 1'b0;
    do_reset();
    cmd_a = 16'h0101; cmd_b = 16'h0202; cmd_op = 4'h1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rstr_valid", 32'(o_rsp_valid), 1);
    rst = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b0;
    check_reset_state("rstr");

`ifdef ALU_SEQ_STATUS_ACCUM_EN
    sel3 = 1'b0;
    do_reset();
    check("acc_rst_count", 32'(d1_ovf_count), 0);
    check("acc_rst_sticky", 32'(d1_ovf_sticky), 0);
    for (int i = 0; i < 257; i++) begin
      push_exp(16'h8000, 1'b1, 1'b0);
      run_op(16'h7FFF, 16'h0001, 4'h1, 1);
    end
    check("acc_sat_count", 32'(d1_ovf_count), 255);
    check("acc_sat_sticky", 32'(d1_ovf_sticky), 1);
    push_exp(16'h8000, 1'b1, 1'b0);
    cmd_a = 16'h7FFF; cmd_b = 16'h0001; cmd_op = 4'h1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_rsp("acc_clr");
    rsp_ready = 1'b1; status_clr = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; status_clr = 1'b0;
    check("acc_clr_count", 32'(d1_ovf_count), 0);
    check("acc_clr_sticky", 32'(d1_ovf_sticky), 0);
    push_exp(16'h0007, 1'b0, 1'b0);
    run_op(16'h0003, 16'h0004, 4'h1, 1);
    check("acc_noovf_count", 32'(d1_ovf_count), 0);
    push_exp(16'h7FFF, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 4'h2, 1);
    check("acc_one_count", 32'(d1_ovf_count), 1);
    check("acc_one_sticky", 32'(d1_ovf_sticky), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
